alu_writeback: RTL and testbench
================================

ALU_WRITEBACK -- requirements
Module: alu_writeback

Interface
REQ-001 Parameter: DATA_W, 16, datapath width.
REQ-002 Parameter: DEPTH, 2, buffer entries (fixed at 2).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  upstream ALU result valid.
REQ-006 in_ready  output  1  block can accept this cycle.
REQ-007 in_result  input  16  ALU result.
REQ-008 in_flags  input  4  ALU flags {N,Z,C,V}.
REQ-009 in_sel  input  5  ALU operation code of this result.
REQ-010 in_dst  input  4  destination register index R0-R15.
REQ-011 in_byte  input  1  byte (.B) operation.
REQ-012 rf_we  output  1  register-file write strobe.
REQ-013 rf_addr  output  4  register-file write index.
REQ-014 rf_wdata  output  16  register-file write data.
REQ-015 rf_ready  input  1  register file accepts write this cycle.
REQ-016 sr_ext_we  input  1  external status-register write (e.g. interrupt/RETI).
REQ-017 sr_ext_data  input  16  external SR value.
REQ-018 sr  output  16  status register (C bit0, Z bit1, N bit2, V bit8).
REQ-019 err  output  1  one-cycle pulse: undefined in_sel dropped.

Function
REQ-020 Buffer SHALL be a 2-entry FIFO with states EMPTY, ONE, FULL; in_ready SHALL equal (state != FULL), registered-state derived, no combinational path from rf_ready.
REQ-021 Accept SHALL occur on an edge where in_valid and in_ready are both high; entry captures result, flags, sel, dst, byte.
REQ-022 Result-writing opcodes SHALL be 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 XOR, 5 CLR, 7 BIC, 8 BIS; flags-only opcodes SHALL be 6 BIT, 9 CMP.
REQ-023 Flag-updating opcodes SHALL be 0,1,2,3,4,6,9; opcodes 5,7,8 SHALL leave SR unchanged.
REQ-024 in_sel 10-31 SHALL be accepted, not buffered, and pulse err the following cycle.
REQ-025 rf_we SHALL be high when head entry is result-writing and dst is not R2 or R3; rf_addr/rf_wdata SHALL be driven from head entry registers.
REQ-026 Byte mode: rf_wdata SHALL be {8'h00, result[7:0]}; word mode: full result.
REQ-027 Head SHALL retire on the edge where rf_we and rf_ready are high, or on the first edge it is head if it needs no rf write.
REQ-028 Minimum latency: accept at edge t -> rf_we high in cycle after t -> retire at edge t+1 if rf_ready high.
REQ-029 On retire of flag-updating entry: SR bits 0,1,2,8 SHALL load C,Z,N,V; other SR bits unchanged.
REQ-030 dst = R2: result (byte-masked) SHALL load the whole SR at retire, flag update suppressed; dst = R3: result discarded.
REQ-031 Simultaneous accept and retire in state ONE SHALL stay ONE; in FULL no accept occurs.
REQ-032 sr_ext_we SHALL override any same-edge retire SR update; the retiring entry still retires.
REQ-033 rf_ready low SHALL hold head and all outputs stable (no drop, no duplicate write).

Reset
REQ-034 On rst high at an edge: state EMPTY, in_ready 1 the next cycle, rf_we 0, rf_addr 0, rf_wdata 0, sr 16'h0000, err 0.
REQ-035 rst mid-operation SHALL discard buffered entries without issuing rf_we; rst outranks sr_ext_we.

Structure
REQ-036 Shared package SHALL hold ALU opcode constants (0-9), SR bit positions, register indices PC/SP/SR/CG, and the buffer-entry typedef.
REQ-037 The 2-entry FIFO SHALL be a sub-module wb_fifo2; opcode classification and SR update stay in alu_writeback.

Verification
REQ-038 ADD result 16'h1234, flags 4'b0000, dst R5, rf_ready=1 -> one rf_we cycle, addr 5, data 16'h1234, SR bits 0,1,2,8 = 0.
REQ-039 CMP result 16'h0000, flags 4'b0100 (Z) -> no rf_we, SR = 16'h0002 after retire.
REQ-040 rf_ready=0, three back-to-back valids -> in_ready low after two accepts; release rf_ready -> two writes in order, third accepted.
REQ-041 ADD.B result 16'hABCD, dst R4 -> rf_wdata 16'h00CD.
REQ-042 BIS dst R2 result 16'h0008 alongside sr_ext_we=1 data 16'h0100 on same edge -> SR = 16'h0100.
REQ-043 in_sel 5'd15 -> no rf_we, err one-cycle pulse; rst asserted with FULL buffer -> rf_we 0, in_ready 1 next cycle.

Source files
------------

// File: rtl/alu_writeback_pkg.sv
// Shared definitions for the ALU writeback slice.
// Holds the ALU opcode constants, status-register bit positions, register
// indices with special meaning, the flag-vector layout, and the buffer-entry
// type that travels through the writeback FIFO.
package alu_writeback_pkg;

  localparam int unsigned WB_DATA_W = 16;

  // ALU operation codes (values 10-31 are undefined)
  localparam logic [4:0] OP_ADD = 5'd0;
  localparam logic [4:0] OP_SUB = 5'd1;
  localparam logic [4:0] OP_MUL = 5'd2;
  localparam logic [4:0] OP_AND = 5'd3;
  localparam logic [4:0] OP_XOR = 5'd4;
  localparam logic [4:0] OP_CLR = 5'd5;
  localparam logic [4:0] OP_BIT = 5'd6;
  localparam logic [4:0] OP_BIC = 5'd7;
  localparam logic [4:0] OP_BIS = 5'd8;
  localparam logic [4:0] OP_CMP = 5'd9;

  // Status-register bit positions
  localparam int unsigned SR_C = 0;
  localparam int unsigned SR_Z = 1;
  localparam int unsigned SR_N = 2;
  localparam int unsigned SR_V = 8;

  // Positions inside the 4-bit ALU flag vector {N,Z,C,V}
  localparam int unsigned FLG_N = 3;
  localparam int unsigned FLG_Z = 2;
  localparam int unsigned FLG_C = 1;
  localparam int unsigned FLG_V = 0;

  // Register indices with special meaning
  localparam logic [3:0] REG_PC = 4'd0;
  localparam logic [3:0] REG_SP = 4'd1;
  localparam logic [3:0] REG_SR = 4'd2;
  localparam logic [3:0] REG_CG = 4'd3;

  typedef struct packed {
    logic [WB_DATA_W-1:0] result;
    logic [3:0]           flags;
    logic [4:0]           sel;
    logic [3:0]           dst;
    logic                 byte_op;
  } wb_entry_t;

endpackage

// File: rtl/alu_writeback_if.sv
// Handshake/bus bundle between the ALU, the writeback block and the
// register file.
//   master : ALU side + register file (drives in_*, rf_ready)
//   slave  : writeback block (drives in_ready, rf_we, rf_addr, rf_wdata)
interface alu_writeback_if #(
  parameter int unsigned DATA_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_result;
  logic [3:0]        in_flags;
  logic [4:0]        in_sel;
  logic [3:0]        in_dst;
  logic              in_byte;

  logic              rf_we;
  logic [3:0]        rf_addr;
  logic [DATA_W-1:0] rf_wdata;
  logic              rf_ready;

  modport master (
    output in_valid, in_result, in_flags, in_sel, in_dst, in_byte, rf_ready,
    input  in_ready, rf_we, rf_addr, rf_wdata
  );

  modport slave (
    input  in_valid, in_result, in_flags, in_sel, in_dst, in_byte, rf_ready,
    output in_ready, rf_we, rf_addr, rf_wdata
  );
endinterface

// File: rtl/alu_writeback_fifo2.sv
// wb_fifo2: two-entry writeback buffer (EMPTY / ONE / FULL).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   push_i          write push_entry_i (never asserted while full)
//   push_entry_i    entry to store
//   pop_i           retire the head entry (never asserted while empty)
//   head_o          head entry, always held in head_q
//   head_valid_o    head entry present
//   ready_o         space available; depends on registered state only
module wb_fifo2
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push_i,
  input  wb_entry_t push_entry_i,
  input  logic      pop_i,
  output wb_entry_t head_o,
  output logic      head_valid_o,
  output logic      ready_o
);

  // State encoding equals occupancy, so FULL is the depth itself.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'(DEPTH)
  } state_e;

  state_e    state_q;
  wb_entry_t head_q;
  wb_entry_t tail_q;

  // Shift-register organisation: the oldest entry always sits in head_q,
  // so a pop from FULL moves tail_q forward.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push_i) begin
            head_q  <= push_entry_i;
            state_q <= ONE;
          end
        end
        ONE: begin
          if (push_i && pop_i) begin
            head_q <= push_entry_i;
          end else if (push_i) begin
            tail_q  <= push_entry_i;
            state_q <= FULL;
          end else if (pop_i) begin
            state_q <= EMPTY;
          end
        end
        FULL: begin
          if (pop_i) begin
            head_q  <= tail_q;
            state_q <= ONE;
          end
        end
        default: state_q <= EMPTY;
      endcase
    end
  end

  assign head_o       = head_q;
  assign head_valid_o = (state_q != EMPTY);
  assign ready_o      = (state_q != FULL);

endmodule

// File: rtl/alu_writeback.sv
// alu_writeback: buffers ALU results, writes them to the register file and
// maintains the status register.
// Ports:
//   clk, rst     clock, synchronous active-high reset
//   bus          in_* ALU result handshake, rf_* register-file write port
//   sr_ext_we    external SR load (wins over any same-edge retire update)
//   sr_ext_data  external SR value
//   sr           status register (C bit0, Z bit1, N bit2, V bit8)
//   err          one-cycle pulse after an undefined opcode is dropped
module alu_writeback
  import alu_writeback_pkg::*;
#(
  parameter int unsigned DATA_W = WB_DATA_W,
  parameter int unsigned DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  alu_writeback_if.slave        bus,
  input  logic                  sr_ext_we,
  input  logic [15:0]           sr_ext_data,
  output logic [15:0]           sr,
  output logic                  err
);

  function automatic logic op_defined(input logic [4:0] s);
    return (s <= OP_CMP);
  endfunction

  function automatic logic writes_result(input logic [4:0] s);
    case (s)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR,
      OP_CLR, OP_BIC, OP_BIS: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  function automatic logic updates_flags(input logic [4:0] s);
    case (s)
      OP_ADD, OP_SUB, OP_MUL, OP_AND, OP_XOR,
      OP_BIT, OP_CMP: return 1'b1;
      default:        return 1'b0;
    endcase
  endfunction

  wb_entry_t         push_entry;
  wb_entry_t         head;
  logic              head_valid;
  logic              fifo_ready;
  logic              accept;
  logic              push;
  logic              pop;
  logic              head_wr;
  logic [DATA_W-1:0] head_result;
  logic [DATA_W-1:0] head_wdata;

  logic [15:0]       sr_q, sr_d;
  logic              err_q, err_d;

  assign accept = bus.in_valid & fifo_ready;
  // Undefined opcodes are consumed by the handshake but never stored.
  assign push   = accept & op_defined(bus.in_sel);

  always_comb begin
    push_entry         = '0;
    push_entry.result  = WB_DATA_W'(bus.in_result);
    push_entry.flags   = bus.in_flags;
    push_entry.sel     = bus.in_sel;
    push_entry.dst     = bus.in_dst;
    push_entry.byte_op = bus.in_byte;
  end

  wb_fifo2 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk          (clk),
    .rst          (rst),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .head_o       (head),
    .head_valid_o (head_valid),
    .ready_o      (fifo_ready)
  );

  // R2 (SR) and R3 (constant generator) are never written through the RF port.
  assign head_wr     = writes_result(head.sel) &&
                       (head.dst != REG_SR) && (head.dst != REG_CG);
  assign head_result = DATA_W'(head.result);
  assign head_wdata  = head.byte_op ? {{(DATA_W-8){1'b0}}, head_result[7:0]}
                                    : head_result;
  // Entries without an RF write retire on their first cycle as head.
  assign pop         = head_valid & (~head_wr | bus.rf_ready);

  always_comb begin
    sr_d = sr_q;
    if (pop) begin
      if (writes_result(head.sel) && (head.dst == REG_SR)) begin
        sr_d = 16'(head_wdata);
      end else if (updates_flags(head.sel)) begin
        sr_d[SR_C] = head.flags[FLG_C];
        sr_d[SR_Z] = head.flags[FLG_Z];
        sr_d[SR_N] = head.flags[FLG_N];
        sr_d[SR_V] = head.flags[FLG_V];
      end
    end
    if (sr_ext_we) begin
      sr_d = sr_ext_data;
    end
  end

  assign err_d = accept & ~op_defined(bus.in_sel);

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q  <= '0;
      err_q <= 1'b0;
    end else begin
      sr_q  <= sr_d;
      err_q <= err_d;
    end
  end

  assign bus.in_ready = fifo_ready;
  assign bus.rf_we    = head_valid & head_wr;
  assign bus.rf_addr  = head.dst;
  assign bus.rf_wdata = head_wdata;
  assign sr           = sr_q;
  assign err          = err_q;

endmodule

// File: tb/tb_alu_writeback.sv
module tb_alu_writeback;

  typedef struct {
    logic [15:0] result;
    logic [3:0]  flags;
    int          sel;
    int          dst;
    bit          byte_op;
  } ent_t;

  logic        clk;
  logic        rst;
  logic        sr_ext_we;
  logic [15:0] sr_ext_data;
  logic [15:0] sr;
  logic        err;

  alu_writeback_if #(.DATA_W(16)) bus ();

  alu_writeback #(
    .DATA_W (16),
    .DEPTH  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .sr_ext_we   (sr_ext_we),
    .sr_ext_data (sr_ext_data),
    .sr          (sr),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: the buffer as a queue of accepted operations
  ent_t        q[$];
  logic [15:0] m_sr;
  bit          m_err;

  function automatic bit is_res(int s);
    return s inside {0, 1, 2, 3, 4, 5, 7, 8};
  endfunction

  function automatic bit is_flag(int s);
    return s inside {0, 1, 2, 3, 4, 6, 9};
  endfunction

  function automatic bit needs_wr(ent_t e);
    return is_res(e.sel) && e.dst != 2 && e.dst != 3;
  endfunction

  function automatic logic [15:0] wdata_of(ent_t e);
    return e.byte_op ? {8'h00, e.result[7:0]} : e.result;
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(bit v, int sel, int dst, logic [15:0] res,
                       logic [3:0] fl, bit b);
    bus.in_valid  = v;
    bus.in_sel    = 5'(sel);
    bus.in_dst    = 4'(dst);
    bus.in_result = res;
    bus.in_flags  = fl;
    bus.in_byte   = b;
  endtask

  // One clock cycle: compare DUT outputs with the model mid-cycle, advance
  // the model by the rules for the coming edge, then let the edge happen.
  task automatic step(output bit acc);
    bit          ret;
    ent_t        h;
    ent_t        n;
    logic [15:0] nsr;
    bit          exp_we;
    @(negedge clk);
    exp_we = (q.size() > 0) && needs_wr(q[0]);
    chk("in_ready", bus.in_ready, q.size() < 2);
    chk("rf_we", bus.rf_we, exp_we);
    if (exp_we) begin
      chk("rf_addr", bus.rf_addr, q[0].dst);
      chk("rf_wdata", bus.rf_wdata, wdata_of(q[0]));
    end
    chk("sr", sr, m_sr);
    chk("err", err, m_err);

    acc = bus.in_valid && (q.size() < 2);
    if (rst) begin
      q.delete();
      m_sr  = 16'h0000;
      m_err = 1'b0;
      acc   = 1'b0;
    end else begin
      nsr = m_sr;
      ret = (q.size() > 0) && (!needs_wr(q[0]) || bus.rf_ready);
      if (ret) begin
        h = q.pop_front();
        if (is_res(h.sel) && h.dst == 2) begin
          nsr = wdata_of(h);
        end else if (is_flag(h.sel)) begin
          nsr[0] = h.flags[1];
          nsr[1] = h.flags[2];
          nsr[2] = h.flags[3];
          nsr[8] = h.flags[0];
        end
      end
      if (sr_ext_we) nsr = sr_ext_data;
      m_sr  = nsr;
      m_err = acc && (int'(bus.in_sel) > 9);
      if (acc && int'(bus.in_sel) <= 9) begin
        n.result  = bus.in_result;
        n.flags   = bus.in_flags;
        n.sel     = int'(bus.in_sel);
        n.dst     = int'(bus.in_dst);
        n.byte_op = bus.in_byte;
        q.push_back(n);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit acc;
    int n;

    rst         = 1'b1;
    sr_ext_we   = 1'b0;
    sr_ext_data = 16'h0000;
    bus.rf_ready = 1'b1;
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst   = 1'b0;
    m_sr  = 16'h0000;
    m_err = 1'b0;
    q.delete();

    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_rf_we", bus.rf_we, 0);
    chk("rst_rf_addr", bus.rf_addr, 0);
    chk("rst_rf_wdata", bus.rf_wdata, 0);
    chk("rst_sr", sr, 16'h0000);
    chk("rst_err", err, 0);

    // ADD to R5
    drive(1, 0, 5, 16'h1234, 4'b0000, 0);
    step(acc);
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    chk("add_rf_we", bus.rf_we, 1);
    chk("add_rf_addr", bus.rf_addr, 5);
    chk("add_rf_wdata", bus.rf_wdata, 16'h1234);
    step(acc);
    chk("add_done", bus.rf_we, 0);
    chk("add_sr_flags", sr & 16'h0107, 16'h0000);

    // CMP sets Z only, no RF write
    drive(1, 9, 9, 16'h0000, 4'b0100, 0);
    step(acc);
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    chk("cmp_no_we", bus.rf_we, 0);
    step(acc);
    chk("cmp_sr", sr, 16'h0002);

    // Back-pressure: three valids with rf_ready low
    bus.rf_ready = 1'b0;
    drive(1, 0, 6, 16'h1111, 4'h0, 0);
    step(acc);
    drive(1, 1, 7, 16'h2222, 4'h1, 0);
    step(acc);
    drive(1, 3, 8, 16'h3333, 4'h2, 0);
    step(acc);
    chk("full_in_ready", bus.in_ready, 0);
    chk("full_head_addr", bus.rf_addr, 6);
    repeat (2) step(acc);
    chk("hold_head_addr", bus.rf_addr, 6);
    bus.rf_ready = 1'b1;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 8) begin
      step(acc);
      n++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $error("FAIL third_accept observed=timeout expected=accept");
    end
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    repeat (3) step(acc);

    // Byte-mode ADD.B to R4
    drive(1, 0, 4, 16'hABCD, 4'h0, 1);
    step(acc);
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    chk("byte_wdata", bus.rf_wdata, 16'h00CD);
    step(acc);

    // BIS to R2 retiring on the same edge as an external SR load
    drive(1, 8, 2, 16'h0008, 4'h0, 0);
    step(acc);
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    sr_ext_we   = 1'b1;
    sr_ext_data = 16'h0100;
    step(acc);
    sr_ext_we = 1'b0;
    chk("ext_override_sr", sr, 16'h0100);
    chk("ext_override_retired", bus.in_ready, 1);
    step(acc);

    // Undefined opcode
    drive(1, 15, 5, 16'hFFFF, 4'hF, 0);
    step(acc);
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    chk("err_pulse", err, 1);
    chk("err_no_we", bus.rf_we, 0);
    step(acc);
    chk("err_clear", err, 0);

    // Reset with a full buffer
    bus.rf_ready = 1'b0;
    drive(1, 2, 10, 16'h5555, 4'h0, 0);
    step(acc);
    drive(1, 4, 11, 16'h6666, 4'h0, 0);
    step(acc);
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    chk("pre_rst_full", bus.in_ready, 0);
    rst          = 1'b1;
    sr_ext_we    = 1'b1;
    sr_ext_data  = 16'hBEEF;
    step(acc);
    rst       = 1'b0;
    sr_ext_we = 1'b0;
    chk("midrst_rf_we", bus.rf_we, 0);
    chk("midrst_in_ready", bus.in_ready, 1);
    chk("midrst_sr", sr, 16'h0000);
    bus.rf_ready = 1'b1;
    step(acc);

    // Randomized traffic against the model
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 2) != 0,
            ($urandom_range(0, 7) == 0) ? int'($urandom_range(10, 31))
                                        : int'($urandom_range(0, 9)),
            int'($urandom_range(0, 15)), 16'($urandom), 4'($urandom),
            $urandom_range(0, 1) == 1);
      bus.rf_ready = $urandom_range(0, 3) != 0;
      sr_ext_we    = $urandom_range(0, 15) == 0;
      sr_ext_data  = 16'($urandom);
      rst          = $urandom_range(0, 99) == 0;
      step(acc);
    end
    rst       = 1'b0;
    sr_ext_we = 1'b0;
    bus.rf_ready = 1'b1;
    drive(0, 0, 0, 16'h0000, 4'h0, 0);
    repeat (4) step(acc);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
